keypad_hex_entry: RTL and testbench

- Input-side counterpart to the 4-digit hex display path: scans a 4x4 hex keypad on a Pmod header, debounces it, and shifts each confirmed key into a 16-bit value.
- That value drives the display's 16-bit digit input in place of the switches.
- Runs on the 100 MHz board clock; the column strobe is generated internally.

---
 rtl/keypad_hex_entry.sv | 206 ++++++++++++++++++++
 tb/tb_keypad_hex_entry.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_hex_entry.sv
// keypad_hex_entry: scans a 4x4 active-low hex keypad, debounces whole-keypad
// snapshots, and shifts every accepted key into a 16-bit hex value (newest
// digit in [3:0]).
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-issue a held key after
// REPEAT_DELAY full scans and then every REPEAT_RATE full scans.
module keypad_hex_entry #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 10,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  input  logic        clr,
  output logic [15:0] value,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("keypad_hex_entry: parameter out of range");
  end

  logic [3:0]        row_meta, row_sync;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        col_idx;
  logic [15:0]       snapshot;
  logic              eval_en;
  logic [4:0]        ones;
  logic [3:0]        hit_pos;
  logic              none, single;
  logic [3:0]        new_code;
  state_t            state;
  logic [CNT_W-1:0]  cnt, step_cnt;
  logic [3:0]        cand;
  logic              continuing, done, accept, rep_fire, emit;
  logic [3:0]        emit_code;

  // Row key at (r, c) -> hex code, with pos = {c, r} as stored in snapshot.
  function automatic logic [3:0] key_map(input logic [3:0] pos);
    case ({pos[1:0], pos[3:2]})
      4'b00_00: key_map = 4'h1;  4'b00_01: key_map = 4'h2;
      4'b00_10: key_map = 4'h3;  4'b00_11: key_map = 4'hA;
      4'b01_00: key_map = 4'h4;  4'b01_01: key_map = 4'h5;
      4'b01_10: key_map = 4'h6;  4'b01_11: key_map = 4'hB;
      4'b10_00: key_map = 4'h7;  4'b10_01: key_map = 4'h8;
      4'b10_10: key_map = 4'h9;  4'b10_11: key_map = 4'hC;
      4'b11_00: key_map = 4'h0;  4'b11_01: key_map = 4'hF;
      4'b11_10: key_map = 4'hE;  default:  key_map = 4'hD;
    endcase
  endfunction

  // Two-flop synchronizer for the asynchronous rows, inverted so 1 = pressed.
  // NOTE: non-blocking assignments keep the two stages distinct flops; blocking
  // here would collapse the chain into a single register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= '0;
      row_sync <= '0;
    end else begin
      row_meta <= ~row;
      row_sync <= row_meta;
    end
  end

  // Column strobe: dwell SCAN_DIV cycles per column, sample rows on the last
  // dwell cycle, and flag an evaluation the cycle after column 3 is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      col_idx  <= '0;
      col      <= 4'b1110;
      snapshot <= '0;
      eval_en  <= 1'b0;
    end else begin
      eval_en <= 1'b0;
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt                      <= '0;
        snapshot[{col_idx, 2'b00} +: 4] <= row_sync;
        col_idx                       <= col_idx + 2'd1;
        col                           <= ~(4'b0001 << (col_idx + 2'd1));
        eval_en                       <= (col_idx == 2'd3);
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  // Classify the snapshot: count set bits and remember the (single) hit.
  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    ones    = '0;
    hit_pos = '0;
    for (int i = 0; i < 16; i++) begin
      if (snapshot[i]) begin
        ones    = ones + 5'd1;
        hit_pos = 4'(i);
      end
    end
  end

  assign none       = (ones == 5'd0);
  assign single     = (ones == 5'd1);
  assign new_code   = key_map(hit_pos);
  // A run continues when the same observation repeats; otherwise it restarts at 1.
  assign continuing = (state == PRESS && single && new_code == cand) ||
                      (state == RELEASE && none);
  assign step_cnt   = continuing ? cnt + CNT_W'(1) : CNT_W'(1);
  assign done       = (step_cnt == CNT_W'(DEBOUNCE_SCANS));
  assign accept     = eval_en && single && (state == IDLE || state == PRESS) && done;
  assign emit       = accept || rep_fire;
  assign emit_code  = accept ? new_code : key_code;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt, rep_step;
  logic             rep_phase;

  assign rep_step = rep_cnt + REP_W'(1);
  assign rep_fire = eval_en && state == HELD && !none &&
                    (rep_step == (rep_phase ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY)));

  // Repeat timer: restarts on every entry to HELD, pauses while in RELEASE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if (eval_en) begin
      if (accept || (state == RELEASE && !none)) begin
        rep_cnt   <= '0;
        rep_phase <= 1'b0;
      end else if (state == HELD && !none) begin
        if (rep_fire) begin
          rep_cnt   <= '0;
          rep_phase <= 1'b1;
        end else begin
          rep_cnt <= rep_step;
        end
      end
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Debounce FSM plus registered outputs; clr only touches value and wins over a shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
      value     <= '0;
    end else begin
      key_valid <= emit;
      if (emit) key_code <= emit_code;
      if (clr) value <= '0;
      else if (emit) value <= {value[11:0], emit_code};

      if (eval_en) begin
        case (state)
          IDLE, PRESS: begin
            if (single) begin
              cand <= new_code;
              cnt  <= step_cnt;
              if (done) begin
                state    <= HELD;
                key_held <= 1'b1;
              end else begin
                state <= PRESS;
              end
            end else begin
              state <= IDLE;
            end
          end
          default: begin  // HELD, RELEASE
            if (none) begin
              cnt <= step_cnt;
              if (done) begin
                state    <= IDLE;
                key_held <= 1'b0;
              end else begin
                state <= RELEASE;
              end
            end else begin
              state <= HELD;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Testbench for keypad_hex_entry: a behavioural 4x4 keypad drives the rows from
// the column strobe; expected key events go to a scoreboard queue and are
// popped by a monitor whenever key_valid pulses.
module tb_keypad_hex_entry;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int SCAN_CYC = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [3:0]  row, col, key_code;
  logic [15:0] value;
  logic        key_valid, key_held;

  logic [15:0] pressed   = '0;  // bit c*4+r = key at (row r, col c) closed
  logic [15:0] exp_value = '0;
  int          checks    = 0;
  int          errors    = 0;
  int          pulse_cnt = 0;
  int          cyc       = 0;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] value;
  } exp_t;
  exp_t exp_q[$];

  keypad_hex_entry #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB), .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .clr(clr),
    .value(value), .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Keypad: a closed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c*4+r] && !col[c]) row[r] = 1'b0;
  end

  // Physical position (c*4+r) of each hex key on the pad.
  function automatic int key_pos(input logic [3:0] code);
    case (code)
      4'h1: key_pos = 0;   4'h4: key_pos = 1;   4'h7: key_pos = 2;   4'h0: key_pos = 3;
      4'h2: key_pos = 4;   4'h5: key_pos = 5;   4'h8: key_pos = 6;   4'hF: key_pos = 7;
      4'h3: key_pos = 8;   4'h6: key_pos = 9;   4'h9: key_pos = 10;  4'hE: key_pos = 11;
      4'hA: key_pos = 12;  4'hB: key_pos = 13;  4'hC: key_pos = 14;  default: key_pos = 15;
    endcase
  endfunction

  // Scoreboard monitor: every key_valid pulse must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && key_valid) begin
      pulse_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_key_valid: got key_code=%h value=%h, expected no pulse", key_code, value);
      end else begin
        e = exp_q.pop_front();
        if (key_code !== e.code || value !== e.value) begin
          errors++;
          $display("FAIL key_event: got key_code=%h value=%h, expected key_code=%h value=%h",
                   key_code, value, e.code, e.value);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic expect_key(input logic [3:0] code, input bit clr_wins);
    exp_t e;
    exp_value = clr_wins ? 16'h0000 : {exp_value[11:0], code};
    e.code  = code;
    e.value = exp_value;
    exp_q.push_back(e);
  endtask

  task automatic hold_scans(input int n);
    repeat (n * SCAN_CYC) @(negedge clk);
  endtask

  task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Press a key long enough to be accepted, then release long enough to clear.
  task automatic tap(input logic [3:0] code, input bit clr_wins);
    expect_key(code, clr_wins);
    pressed = '0;
    pressed[key_pos(code)] = 1'b1;
    hold_scans(5);
    check_val("held_after_press", {15'd0, key_held}, 16'd1);
    check_val("queue_drained", 16'(exp_q.size()), 16'd0);
    pressed = '0;
    hold_scans(5);
    check_val("held_after_release", {15'd0, key_held}, 16'd0);
  endtask

  // Wait until the strobe has just returned to column 0 (start of a scan).
  task automatic align_scan;
    logic [3:0] prev;
    int guard;
    prev  = col;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
      if (col === 4'b1110 && prev === 4'b0111) break;
      prev = col;
    end while (guard < 4 * SCAN_CYC);
    checks++;
    if (guard >= 4 * SCAN_CYC) begin
      errors++;
      $display("FAIL align_timeout: col=%b, expected scan restart", col);
    end
  endtask

  task automatic test_reset;
    logic [3:0] exp_col;
    repeat (3) @(negedge clk);
    check_val("reset_col", {12'd0, col}, 16'h000E);
    check_val("reset_value", value, 16'h0000);
    check_val("reset_flags", {12'd0, key_code}, {12'd0, 4'h0} | {15'd0, key_valid} | {15'd0, key_held});
    check_val("reset_valid_held", {14'd0, key_valid, key_held}, 16'd0);
    rst = 1'b0;
    for (int k = 0; k < 2 * SCAN_CYC; k++) begin
      exp_col = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      check_val("scan_col", {12'd0, col}, {12'd0, exp_col});
      @(negedge clk);
    end
    check_val("idle_value", value, 16'h0000);
  endtask

  task automatic test_single_key;
    tap(4'h5, 1'b0);
    check_val("value_after_5", value, 16'h0005);
    check_val("code_after_5", {12'd0, key_code}, 16'h0005);
  endtask

  task automatic test_sequence;
    tap(4'h1, 1'b0);
    tap(4'h2, 1'b0);
    tap(4'h3, 1'b0);
    tap(4'hA, 1'b0);
    check_val("value_123A", value, 16'h123A);
    tap(4'hD, 1'b0);
    check_val("value_overflow", value, 16'h23AD);
  endtask

  task automatic test_bounce_multi;
    int base;
    base = pulse_cnt;
    align_scan();
    for (int i = 0; i < 3; i++) begin
      pressed = '0;
      pressed[key_pos(4'h7)] = 1'b1;
      hold_scans(2);
      pressed = '0;
      hold_scans(1);
    end
    hold_scans(2);
    check_val("bounce_no_pulse", 16'(pulse_cnt - base), 16'd0);
    pressed = '0;
    pressed[key_pos(4'h1)] = 1'b1;
    pressed[key_pos(4'h5)] = 1'b1;
    hold_scans(5);
    check_val("multi_not_held", {15'd0, key_held}, 16'd0);
    pressed = '0;
    hold_scans(5);
    check_val("multi_no_pulse", 16'(pulse_cnt - base), 16'd0);
    check_val("value_unchanged", value, 16'h23AD);
  endtask

  task automatic test_clr;
    clr = 1'b1;
    tap(4'h9, 1'b1);
    clr = 1'b0;
    check_val("clr_wins_value", value, 16'h0000);
    check_val("clr_key_code", {12'd0, key_code}, 16'h0009);
    tap(4'hB, 1'b0);
    check_val("value_000B", value, 16'h000B);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_value = '0;
    check_val("clr_pulse", value, 16'h0000);
  endtask

  task automatic test_reset_mid_scan;
    int guard;
    expect_key(4'h6, 1'b0);
    pressed = '0;
    pressed[key_pos(4'h6)] = 1'b1;
    guard = 0;
    while (key_held !== 1'b1 && guard < 10 * SCAN_CYC) begin
      @(negedge clk);
      guard++;
    end
    check_val("held_before_reset", {15'd0, key_held}, 16'd1);
    guard = 0;
    while (col !== 4'b1011 && guard < 2 * SCAN_CYC) begin
      @(negedge clk);
      guard++;
    end
    check_val("col_before_reset", {12'd0, col}, 16'h000B);
    #2 rst = 1'b1;
    #1;
    check_val("midreset_col", {12'd0, col}, 16'h000E);
    check_val("midreset_value", value, 16'h0000);
    check_val("midreset_code", {12'd0, key_code}, 16'h0000);
    check_val("midreset_flags", {14'd0, key_valid, key_held}, 16'd0);
    pressed   = '0;
    exp_value = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check_val("restart_col", {12'd0, col}, (k < SCAN_DIV) ? 16'h000E : 16'h000D);
      @(negedge clk);
    end
    check_val("queue_after_reset", 16'(exp_q.size()), 16'd0);
  endtask

`ifdef KEYPAD_AUTOREPEAT_EN
  task automatic test_autorepeat;
    int last, guard;
    for (int i = 0; i < 5; i++) expect_key(4'hE, 1'b0);
    pressed = '0;
    pressed[key_pos(4'hE)] = 1'b1;
    last = 0;
    for (int i = 0; i < 5; i++) begin
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (key_valid !== 1'b1 && guard < 20 * SCAN_CYC);
      checks++;
      if (guard >= 20 * SCAN_CYC) begin
        errors++;
        $display("FAIL repeat_timeout: pulse %0d not seen", i);
      end else if (i > 0 && (cyc - last) != ((i == 1) ? 4 * SCAN_CYC : 2 * SCAN_CYC)) begin
        errors++;
        $display("FAIL repeat_spacing: pulse %0d after %0d cycles, expected %0d",
                 i, cyc - last, (i == 1) ? 4 * SCAN_CYC : 2 * SCAN_CYC);
      end
      last = cyc;
    end
    pressed = '0;
    hold_scans(5);
    check_val("repeat_value", value, 16'hEEEE);
    check_val("repeat_released", {15'd0, key_held}, 16'd0);
  endtask
`endif

  initial begin
    test_reset();
    test_single_key();
    test_sequence();
    test_bounce_multi();
    test_clr();
    test_reset_mid_scan();
`ifdef KEYPAD_AUTOREPEAT_EN
    test_autorepeat();
`endif
    hold_scans(2);
    check_val("final_queue_empty", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
